// File: rtl/svi_lane_capture_fifo.sv
// Lane triplet capture buffer: samples x/y/z on i_valid into a first-word-fall-through FIFO
// and counts overrun drops. Optional duplicate suppression is enabled with `define SVI_LANE_DEDUP_EN.
module svi_lane_capture_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_x,
  input  logic [WIDTH-1:0]           i_y,
  input  logic [WIDTH-1:0]           i_z,
  input  logic                       i_ready,
  input  logic                       i_clr_drop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_a,
  output logic [WIDTH-1:0]           o_b,
  output logic [WIDTH-1:0]           o_c,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_drop,
  output logic [DROP_W-1:0]          o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("svi_lane_capture_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } triplet_t;

  triplet_t          mem [DEPTH];
  triplet_t          in_trip;
  triplet_t          head;
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_nxt;
  logic              full_q;
  logic              drop_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic              dup;
  logic              pop;
  logic              push;
  logic              drop;

  assign in_trip = '{x: i_x, y: i_y, z: i_z};

`ifdef SVI_LANE_DEDUP_EN
  triplet_t last_q;
  logic     has_last_q;

  // Only accepted pushes update the reference; drops and suppressed repeats leave it alone.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_q     <= '0;
      has_last_q <= 1'b0;
    end else if (push) begin
      last_q     <= in_trip;
      has_last_q <= 1'b1;
    end
  end

  assign dup = has_last_q && (in_trip == last_q);
`else
  assign dup = 1'b0;
`endif

  // Full with a simultaneous pop still accepts, so a streaming consumer never causes drops.
  // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    pop       = o_valid & i_ready;
    push      = i_valid & ~dup & ((count_q < CW'(DEPTH)) | pop);
    drop      = i_valid & ~dup & ~push;
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; o_valid gates every read, so stale contents never escape.
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr_q] <= in_trip;
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
    end
  end

  // A clear in the same cycle as a drop wins and that drop is lost.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else if (i_clr_drop) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      drop_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign head       = mem[rptr_q];
  assign o_valid    = (count_q != '0);
  assign o_a        = o_valid ? head.x : '0;
  assign o_b        = o_valid ? head.y : '0;
  assign o_c        = o_valid ? head.z : '0;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_drop     = drop_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_svi_lane_capture_fifo.sv
// Directed bench for svi_lane_capture_fifo (DEPTH=4, WIDTH=8, DROP_W=8); expectations follow
// SVI_LANE_DEDUP_EN when it is defined for the build.
module tb_svi_lane_capture_fifo;

  logic       i_clk;
  logic       i_rstn;
  logic       i_valid;
  logic [7:0] i_x;
  logic [7:0] i_y;
  logic [7:0] i_z;
  logic       i_ready;
  logic       i_clr_drop;
  logic       o_valid;
  logic [7:0] o_a;
  logic [7:0] o_b;
  logic [7:0] o_c;
  logic [2:0] o_count;
  logic       o_full;
  logic       o_drop;
  logic [7:0] o_drop_cnt;

  int checks   = 0;
  int failures = 0;

  svi_lane_capture_fifo #(.WIDTH(8), .DEPTH(4), .DROP_W(8)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_valid    (i_valid),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_z        (i_z),
    .i_ready    (i_ready),
    .i_clr_drop (i_clr_drop),
    .o_valid    (o_valid),
    .o_a        (o_a),
    .o_b        (o_b),
    .o_c        (o_c),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_drop     (o_drop),
    .o_drop_cnt (o_drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    i_valid = v;
    i_x     = x;
    i_y     = y;
    i_z     = z;
  endtask

  task automatic do_reset();
    i_rstn     = 1'b0;
    i_ready    = 1'b0;
    i_clr_drop = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    i_rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    i_rstn     = 1'b0;
    i_ready    = 1'b0;
    i_clr_drop = 1'b0;
    drive(1'b1, 8'hAA, 8'h55, 8'hCC);
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", o_count); end
    checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", o_full); end
    checks++; if ({o_drop, o_drop_cnt} !== 9'd0) begin failures++; $display("FAIL rst_drop got=%b/%0d exp=0/0", o_drop, o_drop_cnt); end
    checks++; if ({o_a, o_b, o_c} !== 24'h0) begin failures++; $display("FAIL rst_data got=%h exp=000000", {o_a, o_b, o_c}); end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    i_rstn = 1'b1;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 8'h00, 8'hFF, 8'h00);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", o_valid); end
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", o_valid); end
    checks++; if ({o_a, o_b, o_c} !== 24'h00FF00) begin failures++; $display("FAIL single_data got=%h exp=00ff00", {o_a, o_b, o_c}); end
    checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", o_count); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", o_valid); end
    checks++; if ({o_a, o_b, o_c} !== 24'h0) begin failures++; $display("FAIL single_pop_data got=%h exp=000000", {o_a, o_b, o_c}); end
    tick();
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", o_count); end
    i_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 8'(i), 8'(8'h10 + i), 8'(i));
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", o_full); end
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", o_count); end
    checks++; if (o_drop !== 1'b1) begin failures++; $display("FAIL ovf_drop got=%b exp=1", o_drop); end
    checks++; if (o_drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", o_drop_cnt); end
    tick();
    checks++; if ({o_a, o_b, o_c} !== 24'h011101) begin failures++; $display("FAIL ovf_head_hold got=%h exp=011101", {o_a, o_b, o_c}); end
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (o_c !== 8'(k) || o_valid !== 1'b1) begin failures++; $display("FAIL ovf_pop_order got=%h/%b exp=%h/1", o_c, o_valid, 8'(k)); end
      tick();
    end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", o_valid); end
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h20, 8'h30, 8'(8'h21 + i));
      tick();
    end
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'h20, 8'h30, 8'(8'h25 + k));
      #1;
      checks++; if (o_c !== 8'(8'h21 + k)) begin failures++; $display("FAIL b2b_head got=%h exp=%h", o_c, 8'(8'h21 + k)); end
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", o_count); end
    checks++; if (o_drop_cnt !== 8'd0 || o_drop !== 1'b0) begin failures++; $display("FAIL b2b_drops got=%0d/%b exp=0/0", o_drop_cnt, o_drop); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_c !== 8'(8'h29 + k)) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", o_c, 8'(8'h29 + k)); end
      tick();
    end
    i_ready = 1'b0;
  endtask

  task automatic test_drop_sat();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h40, 8'h41, 8'(i));
      tick();
    end
    drive(1'b1, 8'h99, 8'h99, 8'h99);
    for (int i = 0; i < 300; i++) tick();
    checks++; if (o_drop_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt got=%0d exp=255", o_drop_cnt); end
    checks++; if (o_drop !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", o_drop); end
    i_clr_drop = 1'b1;
    tick();
    i_clr_drop = 1'b0;
    checks++; if (o_drop_cnt !== 8'd0 || o_drop !== 1'b0) begin failures++; $display("FAIL clr_prio got=%0d/%b exp=0/0", o_drop_cnt, o_drop); end
    tick();
    checks++; if (o_drop_cnt !== 8'd1 || o_drop !== 1'b1) begin failures++; $display("FAIL clr_resume got=%0d/%b exp=1/1", o_drop_cnt, o_drop); end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h50, 8'h60, 8'(8'h70 + i));
      tick();
    end
    checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL arst_pre_count got=%0d exp=3", o_count); end
    #2;
    i_rstn = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL arst_state got=%b/%0d exp=0/0", o_valid, o_count); end
    checks++; if ({o_a, o_b, o_c} !== 24'h0) begin failures++; $display("FAIL arst_data got=%h exp=000000", {o_a, o_b, o_c}); end
    tick();
    i_rstn = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 8'h56);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL arst_no_bypass got=%b exp=0", o_valid); end
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (o_valid !== 1'b1 || {o_a, o_b, o_c} !== 24'h123456) begin failures++; $display("FAIL arst_first_push got=%b/%h exp=1/123456", o_valid, {o_a, o_b, o_c}); end
    checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL arst_first_count got=%0d exp=1", o_count); end
  endtask

  task automatic test_dedup();
    logic [2:0] exp_count;
    logic [7:0] exp_drops;
`ifdef SVI_LANE_DEDUP_EN
    exp_count = 3'd1;
    exp_drops = 8'd0;
`else
    exp_count = 3'd4;
    exp_drops = 8'd6;
`endif
    do_reset();
    drive(1'b1, 8'h00, 8'hFF, 8'h00);
    for (int i = 0; i < 10; i++) tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (o_count !== exp_count) begin failures++; $display("FAIL dedup_count got=%0d exp=%0d", o_count, exp_count); end
    checks++; if (o_drop_cnt !== exp_drops) begin failures++; $display("FAIL dedup_drops got=%0d exp=%0d", o_drop_cnt, exp_drops); end
    drive(1'b1, 8'h00, 8'hFF, 8'h01);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
`ifdef SVI_LANE_DEDUP_EN
    checks++; if (o_count !== 3'd2) begin failures++; $display("FAIL dedup_new_push got=%0d exp=2", o_count); end
`else
    checks++; if (o_drop_cnt !== 8'd7) begin failures++; $display("FAIL dedup_new_drop got=%0d exp=7", o_drop_cnt); end
`endif
  endtask

  initial begin
    i_rstn     = 1'b0;
    i_ready    = 1'b0;
    i_clr_drop = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_drop_sat();
    test_async_reset();
    test_dedup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
